// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART TX scheduler.
package uart_tx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

    // Source IDs double as bit positions in the request/grant vectors.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_RF  = 1'b1
    } src_e;

    localparam logic [1:0] BYTES_ALU = 2'd2;
    localparam logic [1:0] BYTES_RF  = 2'd1;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Producer / transmitter handshake bundle of the UART TX scheduler.
interface uart_tx_scheduler_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [2*DATA_WIDTH-1:0] ALU_OUT;
    logic                    ALU_VLD;
    logic                    ALU_ACK;
    logic [DATA_WIDTH-1:0]   RF_RD_DATA;
    logic                    RF_RD_VLD;
    logic                    RF_ACK;
    logic                    PAR_EN_CFG;
    logic                    PAR_TYP_CFG;
    logic                    TX_BUSY;
    logic [DATA_WIDTH-1:0]   TX_P_DATA;
    logic                    TX_DATA_VALID;
    logic                    TX_PAR_EN;
    logic                    TX_PAR_TYP;
    logic                    SCHED_BUSY;

    // Scheduler side.
    modport slave (
        input  ALU_OUT, ALU_VLD, RF_RD_DATA, RF_RD_VLD,
        input  PAR_EN_CFG, PAR_TYP_CFG, TX_BUSY,
        output ALU_ACK, RF_ACK, TX_P_DATA, TX_DATA_VALID,
        output TX_PAR_EN, TX_PAR_TYP, SCHED_BUSY
    );

    // Producers / transmitter side.
    modport master (
        output ALU_OUT, ALU_VLD, RF_RD_DATA, RF_RD_VLD,
        output PAR_EN_CFG, PAR_TYP_CFG, TX_BUSY,
        input  ALU_ACK, RF_ACK, TX_P_DATA, TX_DATA_VALID,
        input  TX_PAR_EN, TX_PAR_TYP, SCHED_BUSY
    );
endinterface

// File: rtl/uart_tx_scheduler_rr_arb2.sv
// Two-requester round-robin arbiter: combinational grant, registered
// last-served pointer updated when the grant is taken.
module rr_arb2
    import uart_tx_sched_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    src_e last_q;

    // Single requester wins outright; on a tie the one not served last wins.
    always_comb begin
        gnt_o = '0;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_q == SRC_RF) ? 2'b01 : 2'b10;
            default: gnt_o = '0;
        endcase
    end

    // Pointer starts at RF so the ALU wins the first tie.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            last_q <= SRC_RF;
        end else if (en_i) begin
            last_q <= gnt_o[SRC_RF] ? SRC_RF : SRC_ALU;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Sequences ALU results (two bytes, LSB first) and register-file bytes
// onto the UART transmitter's data-valid handshake.
module uart_tx_scheduler
    import uart_tx_sched_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input logic              CLK,
    input logic              RST,
    uart_tx_scheduler_if.slave bus
);

    localparam int unsigned CW = $clog2(BUSY_TIMEOUT + 1);

    state_e                  state_q, state_d;
    logic [2*DATA_WIDTH-1:0] hold_q, hold_d;
    logic [1:0]              bytes_q, bytes_d;
    logic [CW-1:0]           tmo_q, tmo_d;
    logic [DATA_WIDTH-1:0]   txd_q, txd_d;
    logic                    txv_q, txv_d;
    logic                    pen_q, pen_d;
    logic                    ptyp_q, ptyp_d;
    logic                    aack_q, aack_d;
    logic                    rack_q, rack_d;
    logic                    sbusy_q, sbusy_d;

    logic [1:0] req;
    logic [1:0] gnt;
    logic       arb_en;

    assign req[SRC_ALU] = bus.ALU_VLD;
    assign req[SRC_RF]  = bus.RF_RD_VLD;

    rr_arb2 u_arb (
        .clk_i (CLK),
        .rst_i (RST),
        .req_i (req),
        .en_i  (arb_en),
        .gnt_o (gnt)
    );

    // Next-state and registered-output values for the frame sequencer.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        bytes_d = bytes_q;
        tmo_d   = tmo_q;
        txd_d   = txd_q;
        txv_d   = 1'b0;
        pen_d   = pen_q;
        ptyp_d  = ptyp_q;
        aack_d  = 1'b0;
        rack_d  = 1'b0;
        sbusy_d = sbusy_q;
        arb_en  = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    arb_en  = 1'b1;
                    sbusy_d = 1'b1;
                    pen_d   = bus.PAR_EN_CFG;
                    ptyp_d  = bus.PAR_TYP_CFG;
                    state_d = SEND;
                    if (gnt[SRC_ALU]) begin
                        hold_d  = bus.ALU_OUT;
                        bytes_d = BYTES_ALU;
                        aack_d  = 1'b1;
                    end else begin
                        hold_d  = {{DATA_WIDTH{1'b0}}, bus.RF_RD_DATA};
                        bytes_d = BYTES_RF;
                        rack_d  = 1'b1;
                    end
                end
            end
            SEND: begin
                if (!bus.TX_BUSY) begin
                    txd_d   = hold_q[DATA_WIDTH-1:0];
                    txv_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (bus.TX_BUSY) begin
                    state_d = WAIT_DONE;
                end else if (tmo_q == CW'(BUSY_TIMEOUT)) begin
                    state_d = SEND;
                end else begin
                    tmo_d = tmo_q + CW'(1);
                end
            end
            WAIT_DONE: begin
                if (!bus.TX_BUSY) begin
                    bytes_d = bytes_q - 2'd1;
                    if (bytes_q > 2'd1) begin
                        hold_d  = hold_q >> DATA_WIDTH;
                        state_d = SEND;
                    end else begin
                        sbusy_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; everything clears on reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            hold_q  <= '0;
            bytes_q <= '0;
            tmo_q   <= '0;
            txd_q   <= '0;
            txv_q   <= 1'b0;
            pen_q   <= 1'b0;
            ptyp_q  <= 1'b0;
            aack_q  <= 1'b0;
            rack_q  <= 1'b0;
            sbusy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            bytes_q <= bytes_d;
            tmo_q   <= tmo_d;
            txd_q   <= txd_d;
            txv_q   <= txv_d;
            pen_q   <= pen_d;
            ptyp_q  <= ptyp_d;
            aack_q  <= aack_d;
            rack_q  <= rack_d;
            sbusy_q <= sbusy_d;
        end
    end

    assign bus.ALU_ACK       = aack_q;
    assign bus.RF_ACK        = rack_q;
    assign bus.TX_P_DATA     = txd_q;
    assign bus.TX_DATA_VALID = txv_q;
    assign bus.TX_PAR_EN     = pen_q;
    assign bus.TX_PAR_TYP    = ptyp_q;
    assign bus.SCHED_BUSY    = sbusy_q;

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Sequencing controller in front of the UART transmitter: arbitrates between the two system producers that need the serial link. These are ALU results, sent as two bytes LSB-first, and register-file read data, sent as one byte. The block drives the transmitter's parallel-data / data-valid handshake and holds its parity configuration stable for the whole frame. It sits between the system controller datapath and the UART TX top, in the TX clock domain.

## Interface
Parameters:
- DATA_WIDTH, 8, UART byte width; ALU result is 2*DATA_WIDTH.
- BUSY_TIMEOUT, 4, cycles to wait for TX_BUSY to rise after a data-valid pulse before re-issuing.

Ports:
- CLK  in  1  single clock for all logic.
- RST  in  1  synchronous, active-low reset.
- ALU_OUT  in  2*DATA_WIDTH  ALU result to transmit.
- ALU_VLD  in  1  ALU request; level, held until ALU_ACK.
- ALU_ACK  out  1  one-cycle pulse: ALU_OUT captured.
- RF_RD_DATA  in  DATA_WIDTH  register-file byte to transmit.
- RF_RD_VLD  in  1  RF request; level, held until RF_ACK.
- RF_ACK  out  1  one-cycle pulse: RF_RD_DATA captured.
- PAR_EN_CFG, PAR_TYP_CFG  in  1 each  live parity configuration.
- TX_BUSY  in  1  busy flag from the UART transmitter.
- TX_P_DATA  out  DATA_WIDTH  byte to the transmitter.
- TX_DATA_VALID  out  1  one-cycle start pulse to the transmitter.
- TX_PAR_EN, TX_PAR_TYP  out  1 each  parity config, frozen per frame.
- SCHED_BUSY  out  1  high from grant until the final byte completes.

## Operation
- All outputs are registered. Reset value of every output is 0. The state machine resets to IDLE and the round-robin pointer to "RF last served", so the ALU wins the first tie.
- IDLE:
  - Requests are sampled only here.
  - On any request, grant one source: the single requester, or on a tie the source not last served.
  - Capture data into a 2*DATA_WIDTH hold register; RF data is zero-extended.
  - Set bytes_left (ALU=2, RF=1).
  - Latch PAR_EN_CFG/PAR_TYP_CFG into TX_PAR_EN/TX_PAR_TYP.
  - Pulse the matching ACK, set SCHED_BUSY, update the pointer, and go to SEND.
- SEND:
  - If TX_BUSY=0: drive TX_P_DATA = hold[DATA_WIDTH-1:0], pulse TX_DATA_VALID, clear the timeout counter, and go to WAIT_BUSY.
  - Otherwise stay in SEND, covering a transmitter still busy from before a reset.
- WAIT_BUSY:
  - On TX_BUSY=1, go to WAIT_DONE.
  - If the counter reaches BUSY_TIMEOUT with no busy, go back to SEND and re-issue the same byte.
- WAIT_DONE:
  - On TX_BUSY=0, decrement bytes_left.
  - If bytes remain, shift the hold register right by DATA_WIDTH and go to SEND.
  - Otherwise clear SCHED_BUSY and go to IDLE.
- Config changes during a frame have no effect until the next grant. Requests arriving mid-frame wait; they must stay asserted.
- A reset mid-frame abandons the frame: no ACK is repeated and the hold data is lost.

## Timing
- Request sampled at edge k in IDLE → ACK and SCHED_BUSY high in cycle k+1 → TX_DATA_VALID high in cycle k+2 (if TX_BUSY=0), for exactly one cycle.
- TX_P_DATA is stable from the TX_DATA_VALID cycle until the next SEND.
- Second ALU byte: TX_DATA_VALID fires 2 cycles after TX_BUSY falls (WAIT_DONE→SEND→pulse).
- Back-to-back frames: IDLE is occupied for at least 1 cycle between frames. SCHED_BUSY drops for exactly 1 cycle if a request is pending.
- ACK is never high while the FSM is outside IDLE→SEND, so a held VLD cannot be double-granted.

## Structure
- Shared package uart_tx_sched_pkg: state encoding (IDLE, SEND, WAIT_BUSY, WAIT_DONE), source IDs (SRC_ALU, SRC_RF), byte-count constants.
- One sub-module: rr_arb2. This is the two-requester round-robin arbiter with its last-served pointer; it is combinational grant plus a registered pointer update on an enable.
- Top: FSM, hold/shift register, bytes_left counter, timeout counter, config latch.

## Test plan
- Reset with RST=0 while ALU_VLD=1 → all outputs 0; after release, ALU_ACK in cycle 1 and TX_DATA_VALID in cycle 2.
- RF_RD_DATA=0xA5, transmitter model raising busy 1 cycle after valid for 11 cycles → one TX_DATA_VALID with TX_P_DATA=0xA5, RF_ACK once, SCHED_BUSY high throughout.
- ALU_OUT=0x1234 → bytes 0x34 then 0x12; second valid exactly 2 cycles after TX_BUSY falls.
- ALU_VLD and RF_VLD both held from reset → order ALU, RF, ALU, RF… (round-robin alternates).
- PAR_TYP_CFG toggled mid ALU frame → TX_PAR_TYP unchanged until the next grant. Transmitter never raising busy → TX_DATA_VALID re-pulses every BUSY_TIMEOUT+2 cycles with the same byte.
- TX_BUSY held high at reset release with RF_VLD=1 → RF_ACK is issued, but TX_DATA_VALID is withheld until TX_BUSY=0.
